// File: rtl/instr_pipe_regs.sv
// rtl/instr_pipe_regs.sv - fetch and instruction pipeline registers (IR/IR3/IR4) with branch squash and STOP drain
//
// Purpose: owns the fetch PC and the decode/execute/writeback instruction
// registers feeding the pipeline controller; squashes wrong-path work on a
// taken branch, drains and halts on STOP, and counts retired instructions.
//
// Ports:
//   clock          in   1      rising-edge clock
//   reset          in   1      asynchronous active-low reset
//   mem_instr      in   W      instruction memory data at address pc
//   branch_taken   in   1      branch in ir3 resolved taken this cycle
//   branch_target  in   W      branch destination, valid with branch_taken
//   pc             out  W      fetch address
//   ir             out  W      decode-stage instruction
//   pc2            out  W      PC of ir
//   ir3            out  W      execute-stage instruction
//   pc3            out  W      PC of ir3
//   ir4            out  W      writeback-stage instruction
//   halted         out  1      pipe drained after STOP
//   retired_count  out  CNT_W  saturating count of real instructions entering ir4

module instr_pipe_regs #(
  parameter int          W       = 8,
  parameter logic [3:0]  NOP_OP  = 4'b1010,
  parameter logic [3:0]  STOP_OP = 4'b0001,
  parameter int          CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [W-1:0]     mem_instr,
  input  logic             branch_taken,
  input  logic [W-1:0]     branch_target,
  output logic [W-1:0]     pc,
  output logic [W-1:0]     ir,
  output logic [W-1:0]     pc2,
  output logic [W-1:0]     ir3,
  output logic [W-1:0]     pc3,
  output logic [W-1:0]     ir4,
  output logic             halted,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN1, S_DRAIN2, S_HALT} state_t;

  localparam logic [W-1:0]     NOP_WORD = {{(W-4){1'b0}}, NOP_OP};
  localparam logic [W-1:0]     PC_ONE   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            r_state, w_state_nxt;
  logic [W-1:0]      r_pc, r_ir, r_pc2, r_ir3, r_pc3, r_ir4;
  logic [W-1:0]      w_pc_nxt, w_ir_nxt, w_pc2_nxt, w_ir3_nxt, w_pc3_nxt, w_ir4_nxt;
  logic              r_halted, w_halted_nxt;
  logic [CNT_W-1:0]  r_retired;

  logic              w_br_op;
  logic              w_branch;
  logic              w_stop;
  logic              w_ir4_from_ir3;
  logic              w_retire;

  // Only branch opcodes in ir3 can honour branch_taken; anything else is noise.
  assign w_br_op  = (r_ir3[3:0] == 4'b0101) || (r_ir3[3:0] == 4'b1001) ||
                    (r_ir3[3:0] == 4'b1101);
  assign w_branch = (r_state == S_RUN) && branch_taken && w_br_op;
  // A STOP behind a taken branch is on the wrong path, so branch wins.
  assign w_stop   = (r_state == S_RUN) && !w_branch && (r_ir[3:0] == STOP_OP);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_ir_nxt       = r_ir;
    w_pc2_nxt      = r_pc2;
    w_ir3_nxt      = r_ir3;
    w_pc3_nxt      = r_pc3;
    w_ir4_nxt      = r_ir4;
    w_halted_nxt   = r_halted;
    w_ir4_from_ir3 = 1'b0;
    case (r_state)
      S_RUN: begin
        w_ir4_nxt      = r_ir3;
        w_ir4_from_ir3 = 1'b1;
        if (w_branch) begin
          w_pc_nxt  = branch_target;
          w_ir_nxt  = NOP_WORD;
          w_ir3_nxt = NOP_WORD;
          w_pc2_nxt = '0;
          w_pc3_nxt = '0;
        end else if (w_stop) begin
          // Fetch freezes with STOP parked in ir; older work drains out.
          w_ir3_nxt   = NOP_WORD;
          w_state_nxt = S_DRAIN1;
        end else begin
          w_ir_nxt  = mem_instr;
          w_pc2_nxt = r_pc;
          w_ir3_nxt = r_ir;
          w_pc3_nxt = r_pc2;
          w_pc_nxt  = r_pc + PC_ONE;
        end
      end
      S_DRAIN1: begin
        w_ir4_nxt      = r_ir3;
        w_ir4_from_ir3 = 1'b1;
        w_ir3_nxt      = NOP_WORD;
        w_state_nxt    = S_DRAIN2;
      end
      S_DRAIN2: begin
        w_ir4_nxt    = NOP_WORD;
        w_halted_nxt = 1'b1;
        w_state_nxt  = S_HALT;
      end
      default: begin
        w_state_nxt = S_HALT;
      end
    endcase
  end

  assign w_retire = w_ir4_from_ir3 && (r_ir3[3:0] != NOP_OP) && (r_ir3[3:0] != STOP_OP);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc      <= '0;
      r_ir      <= NOP_WORD;
      r_pc2     <= '0;
      r_ir3     <= NOP_WORD;
      r_pc3     <= '0;
      r_ir4     <= NOP_WORD;
      r_halted  <= 1'b0;
      r_retired <= '0;
    end else begin
      r_pc     <= w_pc_nxt;
      r_ir     <= w_ir_nxt;
      r_pc2    <= w_pc2_nxt;
      r_ir3    <= w_ir3_nxt;
      r_pc3    <= w_pc3_nxt;
      r_ir4    <= w_ir4_nxt;
      r_halted <= w_halted_nxt;
      if (w_retire && !(&r_retired)) r_retired <= r_retired + CNT_ONE;
    end
  end

  assign pc            = r_pc;
  assign ir            = r_ir;
  assign pc2           = r_pc2;
  assign ir3           = r_ir3;
  assign pc3           = r_pc3;
  assign ir4           = r_ir4;
  assign halted        = r_halted;
  assign retired_count = r_retired;

endmodule

// File: tb/tb_instr_pipe_regs.sv
// tb/tb_instr_pipe_regs.sv - scoreboard bench for instr_pipe_regs

module tb_instr_pipe_regs;

  localparam int F_PC = 0, F_IR = 1, F_PC2 = 2, F_IR3 = 3, F_PC3 = 4, F_IR4 = 5,
                 F_HLT = 6, F_RET = 7;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  mem_instr;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic [7:0]  pc, ir, pc2, ir3, pc3, ir4;
  logic        halted;
  logic [15:0] retired_count;

  logic [7:0]  mem [256];

  instr_pipe_regs dut (
    .clock         (clock),
    .reset         (reset),
    .mem_instr     (mem_instr),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
    .ir            (ir),
    .pc2           (pc2),
    .ir3           (ir3),
    .pc3           (pc3),
    .ir4           (ir4),
    .halted        (halted),
    .retired_count (retired_count)
  );

  assign mem_instr = mem[pc];

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int    c;
    string nm;
    int    f;
    int    v;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic int get_field(int f);
    case (f)
      F_PC:    return int'(pc);
      F_IR:    return int'(ir);
      F_PC2:   return int'(pc2);
      F_IR3:   return int'(ir3);
      F_PC3:   return int'(pc3);
      F_IR4:   return int'(ir4);
      F_HLT:   return int'(halted);
      default: return int'(retired_count);
    endcase
  endfunction

  task automatic push(input int d, input string nm, input int f, input int v);
    exp_t e;
    e.c  = cyc + d;
    e.nm = nm;
    e.f  = f;
    e.v  = v;
    q.push_back(e);
  endtask

  initial begin
    forever begin
      @(negedge clock);
      while (q.size() > 0 && q[0].c <= cyc) begin
        exp_t e;
        int   act;
        e   = q.pop_front();
        act = get_field(e.f);
        n_tests++;
        if (e.c < cyc || act != e.v) begin
          n_fail++;
          $display("FAIL %s cyc=%0d due=%0d: got 0x%0h expected 0x%0h", e.nm, cyc, e.c, act, e.v);
        end
      end
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic push_reset_checks();
    push(0, "rst_pc",  F_PC,  0);
    push(0, "rst_ir",  F_IR,  'h0A);
    push(0, "rst_pc2", F_PC2, 0);
    push(0, "rst_ir3", F_IR3, 'h0A);
    push(0, "rst_pc3", F_PC3, 0);
    push(0, "rst_ir4", F_IR4, 'h0A);
    push(0, "rst_hlt", F_HLT, 0);
    push(0, "rst_ret", F_RET, 0);
  endtask

  task automatic start_phase();
    @(posedge clock);
    #2;
    reset = 1'b0;
    branch_taken = 1'b0;
    push_reset_checks();
    @(posedge clock);
    #2;
    for (int i = 0; i < 256; i++) mem[i] = 8'h0A;
  endtask

  int b;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h0A;

    start_phase();
    mem[0] = 8'h44; mem[1] = 8'h16; mem[2] = 8'h0A; mem[3] = 8'h35;
    mem[4] = 8'h27; mem[5] = 8'h38;
    reset = 1'b1;
    b = cyc;
    push(1, "t1_ir",     F_IR,  'h44);
    push(1, "t1_pc2",    F_PC2, 0);
    push(1, "t1_pc",     F_PC,  1);
    push(2, "t1_ir3",    F_IR3, 'h44);
    push(2, "t1_ir_b",   F_IR,  'h16);
    push(2, "t1_pc3",    F_PC3, 0);
    push(3, "t1_ir4",    F_IR4, 'h44);
    push(3, "t1_ret",    F_RET, 1);
    push(4, "t1_ir4_b",  F_IR4, 'h16);
    push(4, "t1_ret_b",  F_RET, 2);
    push(4, "nb_pc2",    F_PC2, 3);
    push(4, "nb_ir",     F_IR,  'h35);
    push(4, "nb_pc",     F_PC,  4);
    push(5, "t2_ir3",    F_IR3, 'h35);
    push(5, "t2_pc3",    F_PC3, 3);
    push(6, "t2_pc",     F_PC,  'h20);
    push(6, "t2_ir",     F_IR,  'h0A);
    push(6, "t2_ir3_sq", F_IR3, 'h0A);
    push(6, "t2_ir4",    F_IR4, 'h35);
    push(6, "t2_pc2",    F_PC2, 0);
    push(6, "t2_pc3",    F_PC3, 0);
    push(6, "t2_ret",    F_RET, 3);
    push(7, "t2_pc_b",   F_PC,  'h21);
    push(7, "t2_pc2_b",  F_PC2, 'h20);
    push(9, "t2_ret_b",  F_RET, 3);
    wait_to(b + 3); branch_taken = 1'b1; branch_target = 8'h80;
    wait_to(b + 4); branch_taken = 1'b0;
    wait_to(b + 5); branch_taken = 1'b1; branch_target = 8'h20;
    wait_to(b + 6); branch_taken = 1'b0;
    wait_to(b + 10);

    start_phase();
    mem[0] = 8'h09; mem[1] = 8'h01; mem[2] = 8'h33; mem[8'h40] = 8'h62;
    reset = 1'b1;
    b = cyc;
    push(2, "t4_ir3",   F_IR3, 'h09);
    push(2, "t4_ir",    F_IR,  'h01);
    push(3, "t4_pc",    F_PC,  'h40);
    push(3, "t4_ir_sq", F_IR,  'h0A);
    push(3, "t4_ir3",   F_IR3, 'h0A);
    push(3, "t4_ir4",   F_IR4, 'h09);
    push(3, "t4_hlt",   F_HLT, 0);
    push(4, "t4_ir_b",  F_IR,  'h62);
    push(4, "t4_pc2",   F_PC2, 'h40);
    push(6, "t4_ir4_b", F_IR4, 'h62);
    push(8, "t4_hlt_b", F_HLT, 0);
    push(8, "t4_ret",   F_RET, 2);
    push(8, "t4_pc_b",  F_PC,  'h45);
    wait_to(b + 2); branch_taken = 1'b1; branch_target = 8'h40;
    wait_to(b + 3); branch_taken = 1'b0;
    wait_to(b + 9);

    start_phase();
    mem[0] = 8'h43; mem[1] = 8'h52; mem[2] = 8'h01; mem[3] = 8'h77;
    reset = 1'b1;
    b = cyc;
    push(3,  "t3_ir",      F_IR,  'h01);
    push(3,  "t3_pc",      F_PC,  3);
    push(4,  "t3_pc_hold", F_PC,  3);
    push(4,  "t3_pc2",     F_PC2, 2);
    push(4,  "t3_ir_hold", F_IR,  'h01);
    push(4,  "t3_ir3",     F_IR3, 'h0A);
    push(4,  "t3_ir4",     F_IR4, 'h52);
    push(4,  "t3_ret",     F_RET, 2);
    push(4,  "t3_hlt4",    F_HLT, 0);
    push(5,  "t3_ir4_nop", F_IR4, 'h0A);
    push(5,  "t3_hlt5",    F_HLT, 0);
    push(6,  "t3_hlt6",    F_HLT, 1);
    push(10, "t3_pc_fz",   F_PC,  3);
    push(10, "t3_ir_fz",   F_IR,  'h01);
    push(10, "t3_ir4_fz",  F_IR4, 'h0A);
    push(10, "t3_hlt_fz",  F_HLT, 1);
    push(10, "t3_ret_fz",  F_RET, 2);
    push(10, "t3_pc2_fz",  F_PC2, 2);
    wait_to(b + 7); branch_taken = 1'b1; branch_target = 8'h55;
    wait_to(b + 9); branch_taken = 1'b0;
    wait_to(b + 11);

    start_phase();
    mem[0] = 8'h43; mem[1] = 8'h52; mem[2] = 8'h01; mem[3] = 8'h77;
    reset = 1'b1;
    b = cyc;
    push(4, "t6_ir4", F_IR4, 'h52);
    wait_to(b + 4);

    start_phase();
    n_tests++;
    if (pc != 8'h00) begin
      n_fail++;
      $display("FAIL t6_direct_pc: got 0x%0h expected 0x0", pc);
    end
    n_tests++;
    if (ir != 8'h0A) begin
      n_fail++;
      $display("FAIL t6_direct_ir: got 0x%0h expected 0xa", ir);
    end
    n_tests++;
    if (ir4 != 8'h0A) begin
      n_fail++;
      $display("FAIL t6_direct_ir4: got 0x%0h expected 0xa", ir4);
    end
    n_tests++;
    if (halted != 1'b0) begin
      n_fail++;
      $display("FAIL t6_direct_hlt: got 0x%0h expected 0x0", halted);
    end
    n_tests++;
    if (retired_count != 16'h0000) begin
      n_fail++;
      $display("FAIL t6_direct_ret: got 0x%0h expected 0x0", retired_count);
    end
    mem[0] = 8'h05;
    reset = 1'b1;
    b = cyc;
    push(1, "t5_ir",      F_IR,  'h05);
    push(1, "t5_pc",      F_PC,  1);
    push(2, "t5_ir3",     F_IR3, 'h05);
    push(3, "t5_pc_fe",   F_PC,  'hFE);
    push(3, "t5_ret",     F_RET, 1);
    push(4, "t5_pc_ff",   F_PC,  'hFF);
    push(4, "t5_pc2_fe",  F_PC2, 'hFE);
    push(5, "t5_pc_00",   F_PC,  'h00);
    push(5, "t5_pc2_ff",  F_PC2, 'hFF);
    push(6, "t5_pc_01",   F_PC,  'h01);
    push(6, "t5_pc2_00",  F_PC2, 'h00);
    push(7, "t5_ret_nop", F_RET, 1);
    wait_to(b + 2); branch_taken = 1'b1; branch_target = 8'hFE;
    wait_to(b + 3); branch_taken = 1'b0;
    wait_to(b + 8);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clock);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: never checked, expected 0x%0h", e.nm, e.v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
